lamp_monitor: RTL and testbench
===============================

LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 The block SHALL have one parameter, LAMP_W: default 16; width of the observed lamp bus.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset; synchronous, active-high.
REQ-004 The block SHALL have port lamp, input, LAMP_W bits: observed lamp bus from the lamp pattern generator.
REQ-005 The block SHALL have port flick, input, 1 bit: the same flick request that drives the generator.
REQ-006 The block SHALL have port level, output, 5 bits: number of lit lamps, 0..16.
REQ-007 The block SHALL have port therm_ok, output, 1 bit: the sampled lamp is a right-aligned thermometer code (2^k-1).
REQ-008 The block SHALL have port phase, output, 3 bits: the decoded sequence phase.
REQ-009 The block SHALL have port seq_err, output, 1 bit: sticky protocol-violation flag.
REQ-010 The block SHALL have port seq_done, output, 1 bit: one-cycle pulse when a full sequence completes.
REQ-011 The block SHALL have port seq_cnt, output, 8 bits: count of completed sequences; saturates at 255.

Function
REQ-012 Stage 1 SHALL register level = popcount(lamp), therm_ok, and flick_q = flick; latency from lamp to level is 1 cycle.
REQ-013 Stage 2 SHALL register level_d = previous level; the FSM compares level with level_d, so phase, seq_err and seq_done lag lamp by 2 cycles.
REQ-014 Step rule: each cycle, level - level_d SHALL be in {-1, 0, +1}; a larger step, or therm_ok = 0, is a violation.
REQ-015 The FSM SHALL have the states IDLE=0, UP15=1, DN6=2, UP10=3, DN1=4, UP5=5, DN0=6; encoding 7 is illegal and SHALL go to IDLE with seq_err set.
REQ-016 Hold cycles (level equal to level_d) SHALL be legal in every state and cause no transition.
REQ-017 IDLE: a step from 0 to 1 SHALL go to UP15; a rise from any other level is a violation.
REQ-018 UP15: a reversal at peak 15 (level 14 after 15) SHALL go to DN6.
REQ-019 DN6: a rise from 6 to 7 SHALL go to UP15 if flick_q was 1 on the level-6 sample; otherwise it SHALL go to UP10.
REQ-020 UP10: a reversal at peak 10 SHALL go to DN1.
REQ-021 DN1: a rise from 1 to 2 SHALL go to UP5.
REQ-022 DN1: a rise from 5 to 6 with flick_q = 1 on the level-5 sample SHALL go to UP10.
REQ-023 UP5: a reversal at peak 5 SHALL go to DN0.
REQ-024 DN0: reaching level 0 SHALL go to IDLE, pulse seq_done for one cycle, and increment seq_cnt (saturating at 255).
REQ-025 Any of the following SHALL be a violation: a rise in a DN state other than at the listed valleys, a fall in an UP state other than at the listed peak, or exceeding the state's peak.
REQ-026 On a violation, the block SHALL set seq_err, hold it until rst, and move the FSM to IDLE, with no seq_done and no seq_cnt change.
REQ-027 After a violation, IDLE SHALL ignore all activity until level = 0 has been seen, then accept 0 to 1 normally.
REQ-028 Simultaneous violation and DN0 completion: the violation SHALL win, with no seq_done.
REQ-029 seq_cnt at 255 SHALL hold 255; seq_done still pulses.

Reset
REQ-030 On rst = 1 at a clock edge, the block SHALL set level = 0, level_d = 0, therm_ok = 1, flick_q = 0, phase = IDLE, seq_err = 0, seq_done = 0, seq_cnt = 0, with the IDLE resync requirement cleared.
REQ-031 A reset in mid-sequence SHALL abandon the sequence without setting seq_err or pulsing seq_done.

Structure
REQ-032 A shared package SHALL hold LAMP_W, the phase encodings, and the peak/valley constants 15, 6, 10, 1, 5 and 0.
REQ-033 One sub-module, lamp_decode, SHALL be combinational and produce popcount and the thermometer check; the top holds the registers and the FSM.

Verification
REQ-034 Full legal sequence: lamp steps 0 to 0x7FFF, down to 0x003F, up to 0x03FF, down to 0x0001, up to 0x001F, down to 0, flick = 0 -> phase walks 1,2,3,4,5,6,0; one seq_done pulse; seq_cnt = 1; seq_err = 0.
REQ-035 Flick restart: flick = 1 when lamp = 0x003F in DN6, then lamp rises to 0x007F -> phase = UP15, seq_err = 0.
REQ-036 Non-thermometer value: lamp = 0x0005 at any point -> therm_ok = 0 after 1 cycle, seq_err = 1 after 2 cycles, phase = IDLE; seq_err stays 1.
REQ-037 Step jump: lamp goes from 0x0003 to 0x000F -> seq_err = 1; after that, lamp = 0 then 0x0001 -> phase = UP15.
REQ-038 Saturation: run 256 legal sequences -> seq_cnt = 255 with a seq_done pulse on the last one.
REQ-039 Reset mid-sequence: rst = 1 while phase = UP10 -> all outputs at their reset values on the next cycle, seq_err = 0.

Source files
------------

// File: rtl/lamp_monitor_pkg.sv
// lamp_monitor_pkg: shared widths, phase encodings, turning-point levels
// and small helpers used by the lamp sequence monitor.
package lamp_monitor_pkg;

  // Default width of the observed lamp bus and of the lit-lamp count.
  localparam int LAMP_W  = 16;
  localparam int LEVEL_W = 5;

  // Sequence phases. Each UP phase is immediately followed by its DN phase
  // in the encoding, so a reversal at a peak is simply "phase + 1".
  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_UP15    = 3'd1;
  localparam logic [2:0] PH_DN6     = 3'd2;
  localparam logic [2:0] PH_UP10    = 3'd3;
  localparam logic [2:0] PH_DN1     = 3'd4;
  localparam logic [2:0] PH_UP5     = 3'd5;
  localparam logic [2:0] PH_DN0     = 3'd6;
  localparam logic [2:0] PH_ILLEGAL = 3'd7;

  // Peak and valley levels of the legal lamp sequence.
  localparam logic [LEVEL_W-1:0] LVL_PEAK_15  = 5'd15;
  localparam logic [LEVEL_W-1:0] LVL_VALLEY_6 = 5'd6;
  localparam logic [LEVEL_W-1:0] LVL_PEAK_10  = 5'd10;
  localparam logic [LEVEL_W-1:0] LVL_VALLEY_1 = 5'd1;
  localparam logic [LEVEL_W-1:0] LVL_PEAK_5   = 5'd5;
  localparam logic [LEVEL_W-1:0] LVL_ZERO     = 5'd0;

  // Saturation limit of the completed-sequence counter.
  localparam logic [7:0] SEQ_CNT_MAX = 8'hFF;

  // Relationship between two consecutive level samples.
  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_RISE = 2'd1,
    STEP_FALL = 2'd2,
    STEP_JUMP = 2'd3
  } step_t;

  // One registered observation of the lamp bus.
  typedef struct packed {
    logic [LEVEL_W-1:0] level;
    logic               therm_ok;
    logic               flick;
  } sample_t;

  // An empty bus is a valid thermometer code, hence therm_ok = 1.
  localparam sample_t SAMPLE_RESET = '{level: 5'd0, therm_ok: 1'b1, flick: 1'b0};

  // Classify the move from the previous level to the current one.
  function automatic step_t classify_step(input logic [LEVEL_W-1:0] cur,
                                          input logic [LEVEL_W-1:0] prev);
    step_t s;
    if (cur == prev)
      s = STEP_HOLD;
    else if (cur == prev + LEVEL_W'(1))
      s = STEP_RISE;
    else if (prev == cur + LEVEL_W'(1))
      s = STEP_FALL;
    else
      s = STEP_JUMP;
    return s;
  endfunction

  // Peak level of an UP phase; zero for any other phase.
  function automatic logic [LEVEL_W-1:0] peak_of(input logic [2:0] ph);
    logic [LEVEL_W-1:0] p;
    case (ph)
      PH_UP15: p = LVL_PEAK_15;
      PH_UP10: p = LVL_PEAK_10;
      PH_UP5:  p = LVL_PEAK_5;
      default: p = LVL_ZERO;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/lamp_monitor_lamp_decode.sv
// lamp_decode: combinational popcount of the lamp bus plus a check that the
// bus holds a right-aligned thermometer code (2^k - 1).
module lamp_decode #(
  parameter int LAMP_W = lamp_monitor_pkg::LAMP_W
) (
  input  logic [LAMP_W-1:0] lamp,
  output logic [4:0]        count,
  output logic              therm_ok
);
  import lamp_monitor_pkg::*;

  // Count lit lamps; the 5-bit result covers buses of up to 31 lamps.
  always_comb begin
    count = '0;
    for (int i = 0; i < LAMP_W; i++) begin
      count = count + LEVEL_W'(lamp[i]);
    end
  end

  // A right-aligned run of ones has no bit in common with itself plus one;
  // the all-ones bus wraps to zero and is therefore accepted as well.
  always_comb begin
    therm_ok = ((lamp & (lamp + LAMP_W'(1))) == '0);
  end

endmodule

// File: rtl/lamp_monitor.sv
// lamp_monitor: watches the lamp pattern generator output and checks that it
// walks the expected up/down sequence 0 -> 15 -> 6 -> 10 -> 1 -> 5 -> 0,
// including the flick-driven restarts. Stage 1 registers the decoded sample,
// stage 2 keeps the previous sample, and the phase FSM compares the two.
module lamp_monitor #(
  parameter int LAMP_W = lamp_monitor_pkg::LAMP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LAMP_W-1:0] lamp,
  input  logic              flick,
  output logic [4:0]        level,
  output logic              therm_ok,
  output logic [2:0]        phase,
  output logic              seq_err,
  output logic              seq_done,
  output logic [7:0]        seq_cnt
);
  import lamp_monitor_pkg::*;

  logic [LEVEL_W-1:0] pop_count;
  logic               pop_therm;

  sample_t            stage1_d, stage1_q;
  logic [LEVEL_W-1:0] level_prev_d, level_prev_q;
  logic               flick_prev_d, flick_prev_q;

  logic [2:0]         phase_d, phase_q;
  logic               seq_err_d, seq_err_q;
  logic               seq_done_d, seq_done_q;
  logic [7:0]         seq_cnt_d, seq_cnt_q;
  logic               resync_d, resync_q;

  step_t              step;
  logic               bad_sample;
  logic               violation;
  logic               complete;

  lamp_decode #(
    .LAMP_W(LAMP_W)
  ) u_decode (
    .lamp    (lamp),
    .count   (pop_count),
    .therm_ok(pop_therm)
  );

  // Pipeline next values: stage 1 takes the fresh decode, stage 2 keeps the
  // previous stage-1 sample together with the flick seen alongside it.
  always_comb begin
    stage1_d.level    = pop_count;
    stage1_d.therm_ok = pop_therm;
    stage1_d.flick    = flick;
    level_prev_d      = stage1_q.level;
    flick_prev_d      = stage1_q.flick;
  end

  // Phase FSM: judges the step from the previous level to the current one.
  // Any violation forces IDLE, sets the sticky error and arms the resync
  // wait so IDLE ignores the bus until it has seen level 0 again.
  always_comb begin
    phase_d    = phase_q;
    seq_err_d  = seq_err_q;
    seq_done_d = 1'b0;
    seq_cnt_d  = seq_cnt_q;
    resync_d   = resync_q;
    violation  = 1'b0;
    complete   = 1'b0;
    step       = classify_step(stage1_q.level, level_prev_q);
    bad_sample = (step == STEP_JUMP) || !stage1_q.therm_ok;

    case (phase_q)
      PH_IDLE: begin
        if (resync_q) begin
          if (stage1_q.level == LVL_ZERO)
            resync_d = 1'b0;
        end else if (bad_sample) begin
          violation = 1'b1;
        end else if (step == STEP_RISE) begin
          if (level_prev_q == LVL_ZERO)
            phase_d = PH_UP15;
          else
            violation = 1'b1;
        end
      end

      PH_UP15, PH_UP10, PH_UP5: begin
        if (bad_sample) begin
          violation = 1'b1;
        end else if (step == STEP_RISE) begin
          if (stage1_q.level > peak_of(phase_q))
            violation = 1'b1;
        end else if (step == STEP_FALL) begin
          if (level_prev_q == peak_of(phase_q))
            phase_d = phase_q + 3'd1;
          else
            violation = 1'b1;
        end
      end

      PH_DN6: begin
        if (bad_sample) begin
          violation = 1'b1;
        end else if (step == STEP_RISE) begin
          if (level_prev_q == LVL_VALLEY_6)
            phase_d = flick_prev_q ? PH_UP15 : PH_UP10;
          else
            violation = 1'b1;
        end
      end

      PH_DN1: begin
        if (bad_sample) begin
          violation = 1'b1;
        end else if (step == STEP_RISE) begin
          if (level_prev_q == LVL_VALLEY_1)
            phase_d = PH_UP5;
          else if ((level_prev_q == LVL_PEAK_5) && flick_prev_q)
            phase_d = PH_UP10;
          else
            violation = 1'b1;
        end
      end

      PH_DN0: begin
        if (bad_sample) begin
          violation = 1'b1;
        end else if (step == STEP_RISE) begin
          violation = 1'b1;
        end else if ((step == STEP_FALL) && (stage1_q.level == LVL_ZERO)) begin
          complete = 1'b1;
        end
      end

      default: begin
        violation = 1'b1;
      end
    endcase

    if (violation) begin
      seq_err_d = 1'b1;
      phase_d   = PH_IDLE;
      resync_d  = 1'b1;
    end else if (complete) begin
      phase_d    = PH_IDLE;
      seq_done_d = 1'b1;
      if (seq_cnt_q != SEQ_CNT_MAX)
        seq_cnt_d = seq_cnt_q + 8'd1;
    end
  end

  // State registers with synchronous reset; reset abandons any sequence in
  // flight without reporting an error or a completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q     <= SAMPLE_RESET;
      level_prev_q <= LVL_ZERO;
      flick_prev_q <= 1'b0;
      phase_q      <= PH_IDLE;
      seq_err_q    <= 1'b0;
      seq_done_q   <= 1'b0;
      seq_cnt_q    <= 8'd0;
      resync_q     <= 1'b0;
    end else begin
      stage1_q     <= stage1_d;
      level_prev_q <= level_prev_d;
      flick_prev_q <= flick_prev_d;
      phase_q      <= phase_d;
      seq_err_q    <= seq_err_d;
      seq_done_q   <= seq_done_d;
      seq_cnt_q    <= seq_cnt_d;
      resync_q     <= resync_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    level    = stage1_q.level;
    therm_ok = stage1_q.therm_ok;
    phase    = phase_q;
    seq_err  = seq_err_q;
    seq_done = seq_done_q;
    seq_cnt  = seq_cnt_q;
  end

endmodule

// File: tb/tb_lamp_monitor.sv
// tb_lamp_monitor: randomized and directed stimulus for lamp_monitor, checked
// every cycle against a behavioural model plus a set of literal expectations.
module tb_lamp_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lamp;
  logic        flick;
  logic [4:0]  level;
  logic        therm_ok;
  logic [2:0]  phase;
  logic        seq_err;
  logic        seq_done;
  logic [7:0]  seq_cnt;

  always #5 clk = ~clk;

  lamp_monitor #(.LAMP_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .lamp    (lamp),
    .flick   (flick),
    .level   (level),
    .therm_ok(therm_ok),
    .phase   (phase),
    .seq_err (seq_err),
    .seq_done(seq_done),
    .seq_cnt (seq_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Stimulus control
  int cur_lvl  = 0;
  int hold_pct = 0;
  bit noise_en = 1'b0;

  // Observation of the phase walk for the directed full-sequence test
  bit track_on   = 1'b0;
  int last_phase = 0;
  int done_count = 0;
  int phase_log[$];
  int exp_walk[7] = '{1, 2, 3, 4, 5, 6, 0};

  // Behavioural model: levels as integers, phases as integers with the
  // turning points held in tables.
  int m_level, m_therm, m_flick, m_prev, m_pflick;
  int m_phase, m_err, m_done, m_cnt, m_resync;
  int md_cur, md_prv, md_step, md_next;
  bit md_bad, md_viol, md_fin;
  int peak_tab[7]  = '{0, 15, 0, 10, 0, 5, 0};
  int ex_from[4]   = '{2, 2, 4, 4};
  int ex_valley[4] = '{6, 6, 1, 5};
  int ex_flick[4]  = '{1, 0, -1, 1};
  int ex_to[4]     = '{1, 3, 5, 3};

  function automatic logic [15:0] lamp_of(input int n);
    logic [16:0] v;
    v = (17'd1 << n) - 17'd1;
    return v[15:0];
  endfunction

  function automatic int is_therm(input logic [15:0] v);
    int r;
    r = 0;
    for (int k = 0; k <= 16; k++) begin
      if (v == lamp_of(k)) r = 1;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update on every rising edge, using the inputs the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      m_level = 0; m_therm = 1; m_flick = 0; m_prev = 0; m_pflick = 0;
      m_phase = 0; m_err = 0; m_done = 0; m_cnt = 0; m_resync = 0;
    end else begin
      md_cur  = m_level;
      md_prv  = m_prev;
      md_step = md_cur - md_prv;
      md_bad  = (m_therm == 0) || (md_step > 1) || (md_step < -1);
      md_viol = 1'b0;
      md_fin  = 1'b0;
      md_next = m_phase;
      m_done  = 0;
      if (m_phase == 0) begin
        if (m_resync != 0) begin
          if (md_cur == 0) m_resync = 0;
        end else if (md_bad || (md_step == 1 && md_prv != 0)) begin
          md_viol = 1'b1;
        end else if (md_step == 1) begin
          md_next = 1;
        end
      end else if (md_bad) begin
        md_viol = 1'b1;
      end else if (md_step == 0) begin
      end else if (m_phase % 2 == 1) begin
        if (md_step == 1) begin
          if (md_cur > peak_tab[m_phase]) md_viol = 1'b1;
        end else if (md_prv == peak_tab[m_phase]) begin
          md_next = m_phase + 1;
        end else begin
          md_viol = 1'b1;
        end
      end else begin
        if (md_step == -1) begin
          if (m_phase == 6 && md_cur == 0) md_fin = 1'b1;
        end else begin
          md_viol = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (ex_from[i] == m_phase && ex_valley[i] == md_prv &&
                (ex_flick[i] < 0 || ex_flick[i] == m_pflick)) begin
              md_next = ex_to[i];
              md_viol = 1'b0;
            end
          end
        end
      end
      if (md_viol) begin
        m_err = 1; md_next = 0; m_resync = 1;
      end else if (md_fin) begin
        md_next = 0; m_done = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
      m_phase  = md_next;
      m_prev   = m_level;
      m_pflick = m_flick;
      m_level  = $countones(lamp);
      m_therm  = is_therm(lamp);
      m_flick  = int'(flick);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("level",    int'(level),    m_level);
      checkOutput("therm_ok", int'(therm_ok), m_therm);
      checkOutput("phase",    int'(phase),    m_phase);
      checkOutput("seq_err",  int'(seq_err),  m_err);
      checkOutput("seq_done", int'(seq_done), m_done);
      checkOutput("seq_cnt",  int'(seq_cnt),  m_cnt);
    end
  end

  task automatic applyStimulus(input logic [15:0] l, input logic f, input logic r);
    lamp  = l;
    flick = f;
    rst   = r;
    @(posedge clk);
    #1;
    if (track_on) begin
      if (int'(phase) != last_phase) begin
        phase_log.push_back(int'(phase));
        last_phase = int'(phase);
      end
      if (seq_done) done_count++;
    end
  endtask

  function automatic logic noise_flick(input int n);
    if (!noise_en || n == 5 || n == 6) return 1'b0;
    return 1'($urandom);
  endfunction

  task automatic drive(input int n, input logic fl);
    int holds;
    holds = 0;
    while (hold_pct > 0 && holds < 3 && $urandom_range(99) < hold_pct) holds++;
    repeat (holds) applyStimulus(lamp_of(n), noise_flick(n), 1'b0);
    applyStimulus(lamp_of(n), fl, 1'b0);
    cur_lvl = n;
  endtask

  task automatic walk(input int target);
    while (cur_lvl < target) drive(cur_lvl + 1, noise_flick(cur_lvl + 1));
    while (cur_lvl > target) drive(cur_lvl - 1, noise_flick(cur_lvl - 1));
  endtask

  task automatic run_sequence(input int restart_pct);
    walk(15);
    walk(6);
    for (int r = 0; r < 2 && $urandom_range(99) < restart_pct; r++) begin
      drive(6, 1'b1);
      walk(15);
      walk(6);
    end
    drive(6, 1'b0);
    walk(10);
    walk(5);
    for (int r = 0; r < 2 && $urandom_range(99) < restart_pct; r++) begin
      drive(5, 1'b1);
      walk(10);
      walk(5);
    end
    drive(5, 1'b0);
    walk(1);
    walk(5);
    walk(0);
  endtask

  task automatic do_reset();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    cur_lvl = 0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_level"},    int'(level),    0);
    checkOutput({tag, "_therm_ok"}, int'(therm_ok), 1);
    checkOutput({tag, "_phase"},    int'(phase),    0);
    checkOutput({tag, "_seq_err"},  int'(seq_err),  0);
    checkOutput({tag, "_seq_done"}, int'(seq_done), 0);
    checkOutput({tag, "_seq_cnt"},  int'(seq_cnt),  0);
  endtask

  // Watchdog: the run must end long before this.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    lamp  = 16'h0000;
    flick = 1'b0;

    // Reset state
    applyStimulus(16'h0000, 1'b0, 1'b1);
    cmp_en = 1'b1;
    do_reset();
    check_reset_values("reset");

    // Full legal sequence without flick
    hold_pct = 0;
    noise_en = 1'b0;
    track_on = 1'b1;
    last_phase = 0;
    done_count = 0;
    run_sequence(0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    track_on = 1'b0;
    checkOutput("walk_len", phase_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("walk_%0d", i), (i < phase_log.size()) ? phase_log[i] : -1, exp_walk[i]);
    end
    checkOutput("walk_done_pulses", done_count, 1);
    checkOutput("walk_seq_cnt", int'(seq_cnt), 1);
    checkOutput("walk_seq_err", int'(seq_err), 0);

    // Reset while in UP10
    walk(15);
    walk(6);
    drive(6, 1'b0);
    walk(8);
    checkOutput("mid_phase_up10", int'(phase), 3);
    applyStimulus(lamp_of(8), 1'b0, 1'b1);
    check_reset_values("mid_reset");
    applyStimulus(16'h0000, 1'b0, 1'b0);
    cur_lvl = 0;

    // Flick restart from the level-6 valley
    do_reset();
    walk(15);
    walk(6);
    drive(6, 1'b1);
    checkOutput("flick_phase_dn6", int'(phase), 2);
    drive(7, 1'b0);
    drive(7, 1'b0);
    checkOutput("flick_phase_up15", int'(phase), 1);
    checkOutput("flick_seq_err", int'(seq_err), 0);

    // Non-thermometer sample
    do_reset();
    walk(3);
    applyStimulus(16'h0005, 1'b0, 1'b0);
    checkOutput("nontherm_therm_ok", int'(therm_ok), 0);
    checkOutput("nontherm_level", int'(level), 2);
    applyStimulus(16'h0003, 1'b0, 1'b0);
    checkOutput("nontherm_seq_err", int'(seq_err), 1);
    checkOutput("nontherm_phase", int'(phase), 0);
    repeat (3) applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("nontherm_sticky", int'(seq_err), 1);

    // Step jump, then resync through level 0
    do_reset();
    drive(1, 1'b0);
    drive(2, 1'b0);
    applyStimulus(16'h000F, 1'b0, 1'b0);
    applyStimulus(16'h000F, 1'b0, 1'b0);
    checkOutput("jump_seq_err", int'(seq_err), 1);
    checkOutput("jump_phase", int'(phase), 0);
    drive(0, 1'b0);
    drive(1, 1'b0);
    applyStimulus(16'h0001, 1'b0, 1'b0);
    checkOutput("jump_resync_phase", int'(phase), 1);
    checkOutput("jump_err_held", int'(seq_err), 1);

    // Counter saturation with randomized holds, restarts and flick noise
    do_reset();
    hold_pct = 15;
    noise_en = 1'b1;
    for (int s = 0; s < 255; s++) run_sequence(25);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("sat_cnt_255", int'(seq_cnt), 255);
    hold_pct = 0;
    run_sequence(0);
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("sat_done_pulse", int'(seq_done), 1);
    checkOutput("sat_cnt_hold", int'(seq_cnt), 255);
    checkOutput("sat_seq_err", int'(seq_err), 0);

    // Random mix of glitches, legal fragments and resets
    do_reset();
    hold_pct = 20;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(7))
        0: begin
          applyStimulus(16'($urandom), 1'($urandom), 1'b0);
          cur_lvl = $countones(lamp);
        end
        1: drive($urandom_range(16), 1'($urandom));
        2, 3: begin
          if ($urandom_range(1) == 1 && cur_lvl < 16) drive(cur_lvl + 1, 1'($urandom));
          else if (cur_lvl > 0) drive(cur_lvl - 1, 1'($urandom));
          else drive(0, 1'($urandom));
        end
        4: drive(0, 1'b0);
        5: begin
          walk(0);
          drive(0, 1'b0);
          run_sequence(30);
        end
        6: begin
          applyStimulus(lamp_of(cur_lvl), 1'b0, 1'b1);
          applyStimulus(16'h0000, 1'b0, 1'b0);
          cur_lvl = 0;
        end
        default: walk($urandom_range(16));
      endcase
    end
    applyStimulus(16'h0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
